// File: rtl/i2c_packet_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_packet_assembler_if
// Purpose  : Bundles the byte-stream input, the frame output handshake and
//            the status outputs of the I2C packet assembler.
// Signals  : byte_in/byte_valid/bus_stop  - byte stream from the I2C slave
//            frame_valid/frame_ready       - output frame handshake
//            opcode/frame_data             - held frame contents
//            busy/frame_error/err_code     - status and error reporting
//            drop_count                    - bytes discarded while hunting
// Modports : slave  - the assembler side
//            master - the producer/consumer side (testbench or system)
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_packet_assembler_if #(
  parameter int OP_BITS = 2,
  parameter int FRAME_W = 96
);
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               bus_stop;
  logic               frame_valid;
  logic               frame_ready;
  logic [OP_BITS-1:0] opcode;
  logic [FRAME_W-1:0] frame_data;
  logic               busy;
  logic               frame_error;
  logic [1:0]         err_code;
  logic [7:0]         drop_count;

  modport slave (
    input  byte_in, byte_valid, bus_stop, frame_ready,
    output frame_valid, opcode, frame_data, busy, frame_error, err_code,
           drop_count
  );

  modport master (
    output byte_in, byte_valid, bus_stop, frame_ready,
    input  frame_valid, opcode, frame_data, busy, frame_error, err_code,
           drop_count
  );
endinterface
`default_nettype wire

// File: rtl/i2c_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : i2c_packet_assembler
// Purpose  : Frames a received I2C byte stream. Hunts for a start byte whose
//            upper bits equal START_PREFIX, takes the opcode from its low
//            bits, collects NUM_WORDS*WORD_BYTES payload bytes MSB-first and
//            presents the frame on a valid/ready output register. Aborts on
//            inter-byte timeout or bus STOP, and reports output overrun.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous, active-low reset
//            bus  - i2c_packet_assembler_if.slave (stream in, frame out,
//                   status)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_packet_assembler #(
  parameter int                 OP_BITS        = 2,
  parameter logic [7-OP_BITS:0] START_PREFIX   = 6'b111111,
  parameter int                 NUM_WORDS      = 3,
  parameter int                 WORD_BYTES     = 4,
  parameter int                 TIMEOUT_CYCLES = 100000
) (
  input wire logic clk,
  input wire logic rst,
  i2c_packet_assembler_if.slave bus
);

  localparam int NUM_BYTES = NUM_WORDS * WORD_BYTES;
  localparam int FRAME_W   = NUM_BYTES * 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [CNT_W-1:0]     r_count;
  logic [TMR_W-1:0]     r_timer;
  logic [OP_BITS-1:0]   r_op_stage;
  // Holds all but the last payload byte; the last byte is appended on the
  // fly when the frame commits.
  logic [FRAME_W-9:0]   r_shift;

  logic                 r_frame_valid;
  logic [OP_BITS-1:0]   r_opcode;
  logic [FRAME_W-1:0]   r_frame_data;
  logic                 r_frame_error;
  logic [1:0]           r_err_code;
  logic [7:0]           r_drop_count;

  logic                 w_is_start;
  logic [CNT_W-1:0]     w_count_inc;
  logic [FRAME_W-1:0]   w_shift_next;
  logic                 w_start;
  logic                 w_shift;
  logic                 w_commit;
  logic                 w_drop;
  logic                 w_abort;
  logic [1:0]           w_abort_code;
  logic                 w_load;
  logic                 w_overrun;

  assign w_is_start   = (bus.byte_in[7:OP_BITS] == START_PREFIX);
  assign w_count_inc  = r_count + 1'b1;
  assign w_shift_next = {r_shift, bus.byte_in};

  // A completed frame is taken if the output register is empty or is being
  // emptied by a handshake in this same cycle; otherwise it is an overrun.
  assign w_load    = w_commit && (!r_frame_valid || bus.frame_ready);
  assign w_overrun = w_commit && !w_load;

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    w_abort      = 1'b0;
    w_abort_code = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (bus.byte_valid) begin
          if (w_is_start) begin
            w_start      = 1'b1;
            w_next_state = S_COLLECT;
          end else begin
            w_drop = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (bus.byte_valid) begin
          // The byte is consumed before a coincident STOP is considered, so
          // a STOP on the final byte still yields a good frame.
          w_shift = 1'b1;
          if (w_count_inc == CNT_W'(NUM_BYTES)) begin
            w_commit     = 1'b1;
            w_next_state = S_IDLE;
          end else if (bus.bus_stop) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_STOP;
            w_next_state = S_IDLE;
          end
        end else if (bus.bus_stop) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_STOP;
          w_next_state = S_IDLE;
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_abort      = 1'b1;
          w_abort_code = ERR_TIMEOUT;
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Collection datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count    <= '0;
      r_timer    <= '0;
      r_op_stage <= '0;
      r_shift    <= '0;
    end else if (w_start) begin
      r_count    <= '0;
      r_timer    <= '0;
      r_op_stage <= bus.byte_in[OP_BITS-1:0];
      r_shift    <= '0;
    end else if (w_shift) begin
      r_count <= w_count_inc;
      r_timer <= '0;
      r_shift <= w_shift_next[FRAME_W-9:0];
    end else if (r_state == S_COLLECT && !w_abort) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output register, error reporting and drop counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_valid <= 1'b0;
      r_opcode      <= '0;
      r_frame_data  <= '0;
      r_frame_error <= 1'b0;
      r_err_code    <= 2'b00;
      r_drop_count  <= 8'd0;
    end else begin
      if (w_load) begin
        r_frame_valid <= 1'b1;
        r_opcode      <= r_op_stage;
        r_frame_data  <= w_shift_next;
      end else if (r_frame_valid && bus.frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      r_frame_error <= w_abort || w_overrun;
      if (w_abort) begin
        r_err_code <= w_abort_code;
      end else if (w_overrun) begin
        r_err_code <= ERR_OVERRUN;
      end

      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.opcode      = r_opcode;
  assign bus.frame_data  = r_frame_data;
  assign bus.busy        = (r_state == S_COLLECT);
  assign bus.frame_error = r_frame_error;
  assign bus.err_code    = r_err_code;
  assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire
